// File: rtl/shake_squeeze_reader.sv
// SHAKE256 squeeze-side reader: captures rate blocks into a 2-deep FIFO and streams words over valid/ready.
// Define SQUEEZE_BYTESWAP_EN to byte-reverse each output word (little-endian lane order).
module shake_squeeze_reader #(
   parameter int unsigned RATE   = 1088,
   parameter int unsigned WORD_W = 64,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  out_words,
   input  logic              squeezed,
   input  logic [RATE-1:0]   hash,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              active,
   output logic              overflow,
   output logic              done
);
   localparam int unsigned WORDS = RATE / WORD_W;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;

   logic              sq_q;
   logic              cap, hs, pop, push, finish, accept_start, zero_start;
   logic [1:0]        count;
   logic              rd_ptr, wr_ptr;
   logic [RATE-1:0]   mem [2];
   logic [IDX_W-1:0]  w;
   logic [LEN_W-1:0]  remaining;
   logic              ovf_q, done_q;
   logic [RATE-1:0]   shifted;
   logic [WORD_W-1:0] slice, word_out;

   assign cap          = squeezed & ~sq_q;
   assign hs           = m_valid & m_ready;
   assign finish       = hs & m_last;
   assign pop          = hs & (w == LAST_IDX);
   // A full FIFO still accepts when the head is popped in the same cycle.
   assign push         = cap & (state == RUN) & ((count != 2'd2) | pop);
   assign accept_start = (state == IDLE) & start & (out_words != '0);
   assign zero_start   = (state == IDLE) & start & (out_words == '0);
   assign overflow     = ovf_q;
   assign done         = done_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept_start) state_nx = RUN;
         RUN:  if (finish)       state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_comb begin
      active  = (state == RUN);
      m_valid = active && (count != 2'd0);
      m_last  = m_valid && (remaining == LEN_W'(1));
      m_data  = '0;
      if (m_valid) m_data = word_out;
   end

   always_comb begin
      shifted  = mem[rd_ptr] << (32'(w) * WORD_W);
      slice    = shifted[RATE-1 -: WORD_W];
      word_out = '0;
`ifdef SQUEEZE_BYTESWAP_EN
      for (int unsigned b = 0; b < WORD_W / 8; b++)
         word_out[b*8 +: 8] = slice[(WORD_W/8 - 1 - b)*8 +: 8];
`else
      word_out = slice;
`endif
   end

   always_ff @(posedge clock) begin
      if (push && !finish) mem[wr_ptr] <= hash;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sq_q      <= 1'b0;
         count     <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         w         <= '0;
         remaining <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         sq_q   <= squeezed;
         done_q <= finish | zero_start;
         if (accept_start) begin
            remaining <= out_words;
            ovf_q     <= 1'b0;
            w         <= '0;
            count     <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
         end else if (state == RUN) begin
            if (finish) begin
               // Final word: flush everything, any concurrent capture is discarded.
               remaining <= remaining - 1'b1;
               w         <= '0;
               count     <= '0;
               rd_ptr    <= 1'b0;
               wr_ptr    <= 1'b0;
            end else begin
               if (hs) begin
                  remaining <= remaining - 1'b1;
                  w         <= pop ? '0 : w + 1'b1;
               end
               if (push) wr_ptr <= ~wr_ptr;
               if (pop)  rd_ptr <= ~rd_ptr;
               count <= count + {1'b0, push} - {1'b0, pop};
               if (cap && !push) ovf_q <= 1'b1;
            end
         end
      end
   end
endmodule
